// File: rtl/fpu_dp_pkg.sv
// Shared types and constants for the fpu_dp issue path.
// Opcodes, sequencer states, double-precision width and quiet NaN.
package fpu_dp_pkg;

   localparam int DP_W = 64;

   localparam logic [DP_W-1:0] DP_QNAN = 64'h7FF8_0000_0000_0000;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      MUL = 2'b10,
      DIV = 2'b11
   } fpu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } issue_state_e;

endpackage

// File: rtl/fpu_dp_issue_ctrl.sv
// Request sequencer in front of fpu_dp: one request in flight, operands
// held stable while fpu_dp computes, tagged response with flags/timeout.
// Ports:
//   req_*      valid/ready request (a, b, op, tag)
//   fpu_*      operands/opcode to fpu_dp, result/ready/flags from it
//   rsp_*      valid/ready response (result, tag, ovf, unf, to)
//   sticky_*   accumulated flags, cleared by sticky_clr
//   busy       sequencer not idle
module fpu_dp_issue_ctrl
   import fpu_dp_pkg::*;
#(
   parameter int TAG_W    = 4,
   parameter int MIN_WAIT = 1,
   parameter int TIMEOUT  = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DP_W-1:0]  req_a,
   input  logic [DP_W-1:0]  req_b,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic [DP_W-1:0]  fpu_a,
   output logic [DP_W-1:0]  fpu_b,
   output logic [1:0]       fpu_op,
   input  logic [DP_W-1:0]  fpu_result,
   input  logic             fpu_ready,
   input  logic             fpu_overflow,
   input  logic             fpu_underflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DP_W-1:0]  rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_ovf,
   output logic             rsp_unf,
   output logic             rsp_to,
   input  logic             sticky_clr,
   output logic             sticky_ovf,
   output logic             sticky_unf,
   output logic             sticky_to,
   output logic             busy
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CMIN = CW'(MIN_WAIT);

   issue_state_e state_q, state_d;

   logic [DP_W-1:0]  a_q, b_q;
   fpu_op_e          op_q;
   logic [TAG_W-1:0] tag_q;
   logic [CW-1:0]    cnt_q;

   logic accept, qual, tmo, rsp_hs;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);

   assign fpu_a  = a_q;
   assign fpu_b  = b_q;
   assign fpu_op = op_q;

   assign accept = req_valid && req_ready;
   assign rsp_hs = rsp_valid && rsp_ready;

   // Ready seen in the first MIN_WAIT cycles may belong to the previous op.
   assign qual = (state_q == WAIT) && fpu_ready && (cnt_q >= CMIN);
   assign tmo  = (state_q == WAIT) && !qual && (cnt_q == CMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)       state_d = WAIT;
         WAIT:    if (qual || tmo)  state_d = RESP;
         RESP:    if (rsp_ready)    state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= ADD;
         tag_q      <= '0;
         cnt_q      <= '0;
         rsp_result <= '0;
         rsp_tag    <= '0;
         rsp_ovf    <= 1'b0;
         rsp_unf    <= 1'b0;
         rsp_to     <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            op_q  <= fpu_op_e'(req_op);
            tag_q <= req_tag;
            cnt_q <= '0;
         end else if (state_q == WAIT && cnt_q != CMAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (qual) begin
            rsp_result <= fpu_result;
            rsp_tag    <= tag_q;
            rsp_ovf    <= fpu_overflow;
            rsp_unf    <= fpu_underflow;
            rsp_to     <= 1'b0;
         end else if (tmo) begin
            rsp_result <= DP_QNAN;
            rsp_tag    <= tag_q;
            rsp_ovf    <= 1'b0;
            rsp_unf    <= 1'b0;
            rsp_to     <= 1'b1;
         end
      end
   end

   // Clear and a new event in the same cycle: the event survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
         sticky_unf <= 1'b0;
         sticky_to  <= 1'b0;
      end else begin
         sticky_ovf <= (sticky_ovf && !sticky_clr) || (rsp_hs && rsp_ovf);
         sticky_unf <= (sticky_unf && !sticky_clr) || (rsp_hs && rsp_unf);
         sticky_to  <= (sticky_to  && !sticky_clr) || (rsp_hs && rsp_to);
      end
   end

endmodule

// File: tb/tb_fpu_dp_issue_ctrl.sv
// Self-checking bench for fpu_dp_issue_ctrl: directed scenarios then
// randomized requests against a cycle-index reference model.
module tb_fpu_dp_issue_ctrl;

   localparam int TAG_W    = 4;
   localparam int MIN_WAIT = 1;
   localparam int TIMEOUT  = 64;
   localparam logic [63:0] QNAN = 64'h7FF8000000000000;
   localparam int NEVER = TIMEOUT + 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid = 1'b0;
   logic req_ready;
   logic [63:0] req_a = '0, req_b = '0;
   logic [1:0] req_op = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic [63:0] fpu_a, fpu_b;
   logic [1:0] fpu_op;
   logic [63:0] fpu_result = '0;
   logic fpu_ready = 1'b0, fpu_overflow = 1'b0, fpu_underflow = 1'b0;
   logic rsp_valid;
   logic rsp_ready = 1'b0;
   logic [63:0] rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic rsp_ovf, rsp_unf, rsp_to;
   logic sticky_clr = 1'b0;
   logic sticky_ovf, sticky_unf, sticky_to;
   logic busy;

   int vectors = 0;
   int miscompares = 0;
   logic m_ovf = 1'b0, m_unf = 1'b0, m_to = 1'b0;

   fpu_dp_issue_ctrl #(
      .TAG_W(TAG_W), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
      .fpu_result(fpu_result), .fpu_ready(fpu_ready),
      .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_tag(rsp_tag),
      .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_to(rsp_to),
      .sticky_clr(sticky_clr),
      .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
      .sticky_to(sticky_to), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_sticky();
      chk("sticky_ovf", sticky_ovf, m_ovf);
      chk("sticky_unf", sticky_unf, m_unf);
      chk("sticky_to", sticky_to, m_to);
   endtask

   // rf: cycle index (0 = first cycle after accept) from which fpu_ready
   // is high; negative means high since before accept, NEVER means never.
   task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        input int rf, input logic [63:0] res,
                        input logic ovf, input logic unf,
                        input int hold, input logic clr);
      int e;
      logic to;
      logic [63:0] xr;
      logic xo, xu;
      e = -1;
      for (int n = MIN_WAIT; n < TIMEOUT; n++)
         if (e < 0 && (rf < 0 || n >= rf)) e = n;
      to = (e < 0);
      if (to) e = TIMEOUT - 1;
      xr = to ? QNAN : res;
      xo = to ? 1'b0 : ovf;
      xu = to ? 1'b0 : unf;

      chk("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1;
      req_a = a; req_b = b; req_op = op; req_tag = tag;
      fpu_ready = (rf < 0);
      fpu_result = ~res;
      fpu_overflow = ~ovf;
      fpu_underflow = ~unf;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_op = 2'($urandom);
      req_tag = TAG_W'($urandom);
      chk("fpu_a", fpu_a, a);
      chk("fpu_b", fpu_b, b);
      chk("fpu_op", fpu_op, op);
      chk("busy", busy, 1'b1);
      chk("req_ready_wait", req_ready, 1'b0);

      for (int n = 0; n <= e; n++) begin
         fpu_ready = (rf < 0) || (n >= rf);
         fpu_result = (n == e) ? res : ~res;
         fpu_overflow = (n == e) ? ovf : ~ovf;
         fpu_underflow = (n == e) ? unf : ~unf;
         @(posedge clk); #1;
         chk("rsp_valid_time", rsp_valid, (n == e));
         chk("fpu_a_hold", fpu_a, a);
      end
      fpu_ready = 1'b0;

      chk("rsp_result", rsp_result, xr);
      chk("rsp_tag", rsp_tag, tag);
      chk("rsp_ovf", rsp_ovf, xo);
      chk("rsp_unf", rsp_unf, xu);
      chk("rsp_to", rsp_to, to);

      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         rsp_ready = 1'b0;
         fpu_ready = 1'($urandom);
         fpu_result = {$urandom, $urandom};
         fpu_overflow = 1'($urandom);
         @(posedge clk); #1;
         chk("bp_valid", rsp_valid, 1'b1);
         chk("bp_result", rsp_result, xr);
         chk("bp_tag", rsp_tag, tag);
         chk("bp_to", rsp_to, to);
         chk("bp_req_ready", req_ready, 1'b0);
         chk("bp_busy", busy, 1'b1);
         chk("bp_fpu_b", fpu_b, b);
      end

      rsp_ready = 1'b1;
      sticky_clr = clr;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      sticky_clr = 1'b0;
      req_valid = 1'b0;
      fpu_ready = 1'b0;
      m_ovf = (m_ovf && !clr) || xo;
      m_unf = (m_unf && !clr) || xu;
      m_to  = (m_to && !clr) || to;
      chk("post_rsp_valid", rsp_valid, 1'b0);
      chk("post_busy", busy, 1'b0);
      chk("post_req_ready", req_ready, 1'b1);
      chk_sticky();
   endtask

   initial begin
      #3;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fpu_a", fpu_a, 64'h0);
      chk("rst_rsp_result", rsp_result, 64'h0);
      chk_sticky();
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_req_ready", req_ready, 1'b1);

      // basic add, ready two cycles after accept
      do_op(64'h4010CCCCCCCCCCCD, 64'h400999999999999A, 2'b00, 4'd3,
            1, 64'h401D99999999999A, 1'b0, 1'b0, 0, 1'b0);
      // stale ready held high throughout
      do_op(64'h3FF0000000000000, 64'h4000000000000000, 2'b01, 4'd5,
            -1, 64'hBFF0000000000000, 1'b0, 1'b0, 0, 1'b0);
      // timeout
      do_op(64'h1, 64'h2, 2'b11, 4'd7,
            NEVER, 64'h1234, 1'b1, 1'b1, 0, 1'b0);
      // ready coincident with timeout cycle
      do_op(64'h3, 64'h4, 2'b10, 4'd8,
            TIMEOUT - 1, 64'hCAFEF00DCAFEF00D, 1'b0, 1'b0, 0, 1'b0);
      // backpressure 5 cycles
      do_op(64'hAAAA, 64'hBBBB, 2'b00, 4'd9,
            3, 64'h5555, 1'b0, 1'b0, 5, 1'b0);
      // mul overflow
      do_op(64'h7FE0000000000000, 64'h4000000000000000, 2'b10, 4'd10,
            2, 64'h7FF0000000000000, 1'b1, 1'b0, 0, 1'b0);
      // div underflow with clear at the handshake
      do_op(64'h0010000000000000, 64'h7FE0000000000000, 2'b11, 4'd11,
            1, 64'h0, 1'b0, 1'b1, 1, 1'b1);

      // standalone clear
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0; m_to = 1'b0;
      chk_sticky();

      do_op(64'h5, 64'h6, 2'b00, 4'd12,
            1, 64'h77, 1'b1, 1'b1, 0, 1'b0);

      // reset while in WAIT
      req_valid = 1'b1; req_a = 64'h9999; req_b = 64'h8888;
      req_op = 2'b01; req_tag = 4'd13;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      m_ovf = 1'b0; m_unf = 1'b0; m_to = 1'b0;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", rsp_valid, 1'b0);
      chk("mid_rst_fpu_a", fpu_a, 64'h0);
      chk("mid_rst_fpu_op", fpu_op, 2'b00);
      chk("mid_rst_tag", rsp_tag, 4'd0);
      chk_sticky();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel2_req_ready", req_ready, 1'b1);
      fpu_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("dropped_no_rsp", rsp_valid, 1'b0);
      end
      fpu_ready = 1'b0;

      // randomized requests
      for (int i = 0; i < 24; i++) begin
         int rf, sel;
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      rf = -1;
         else if (sel == 1) rf = NEVER;
         else if (sel == 2) rf = TIMEOUT - 1;
         else               rf = int'($urandom_range(0, 6));
         do_op({$urandom, $urandom}, {$urandom, $urandom},
               2'($urandom), TAG_W'($urandom), rf,
               {$urandom, $urandom}, 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fpu_dp_issue_ctrl.md
Name: fpu_dp_issue_ctrl

Overview:
- Request sequencer directly upstream of fpu_dp; owns the operand/opcode inputs of fpu_dp and consumes its result/Ready/Overflow/Underflow.
- Accepts double-precision operation requests over valid/ready and holds the operands stable while fpu_dp computes.
- Returns one tagged response per request, with per-operation exception flags, a timeout indication and sticky exception status.

Parameters:
- TAG_W, 4, width of request/response tag
- MIN_WAIT, 1, WAIT-state cycles during which fpu_ready is ignored (masks a stale Ready from the previous operation); range 0..TIMEOUT-1
- TIMEOUT, 64, max WAIT-state cycles before a forced timeout response; must be >= 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accept
- req_a  in  64  operand A, IEEE-754 double
- req_b  in  64  operand B, IEEE-754 double
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div
- req_tag  in  TAG_W  request tag
- fpu_a  out  64  to fpu_dp operand A
- fpu_b  out  64  to fpu_dp operand B
- fpu_op  out  2  to fpu_dp opCode
- fpu_result  in  64  from fpu_dp result
- fpu_ready  in  1  from fpu_dp Ready
- fpu_overflow  in  1  from fpu_dp Overflow
- fpu_underflow  in  1  from fpu_dp Underflow
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_result  out  64  captured result
- rsp_tag  out  TAG_W  tag of the request that produced this response
- rsp_ovf, rsp_unf, rsp_to  out  1 each  overflow / underflow / timeout for this response
- sticky_clr  in  1  clear sticky flags
- sticky_ovf, sticky_unf, sticky_to  out  1 each  accumulated flags
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs and registers 0, so req_ready=1 once reset is released. Reset during WAIT or RESP drops the in-flight operation with no response.
- FSM states: IDLE, WAIT, RESP. req_ready = (state==IDLE), combinational from state only.
- IDLE: on req_valid&&req_ready, latch a/b/op/tag, clear cnt to 0, go to WAIT.
- fpu_a/fpu_b/fpu_op are driven from the latched registers at all times. They change only on accept and are stable through WAIT and RESP.
- WAIT: cnt increments every cycle (TIMEOUT-limited width, no wrap). fpu_ready is qualified when cnt >= MIN_WAIT.
  - On qualified fpu_ready: capture fpu_result, fpu_overflow, fpu_underflow; rsp_to=0; go to RESP.
  - Else if cnt == TIMEOUT-1: rsp_result = QNAN (0x7FF8000000000000), rsp_ovf=rsp_unf=0, rsp_to=1; go to RESP.
  - If a qualified fpu_ready and the timeout condition occur in the same cycle, fpu_ready wins.
- Latency: with accept at edge k, the earliest rsp_valid is after edge k+1+MIN_WAIT (MIN_WAIT=1: 2 cycles after accept). Timeout: rsp_valid after edge k+TIMEOUT.
- RESP: rsp_valid=1; all rsp_* fields are registered and held stable until rsp_valid&&rsp_ready, then go to IDLE. The next request is accepted no earlier than the cycle after that handshake (one request in flight, no overlap).
- Sticky flags: on each rsp handshake, OR in rsp_ovf/rsp_unf/rsp_to. sticky_clr clears them. When clear and set coincide, set wins so a new event is never lost.
- fpu_ready/flags arriving outside WAIT are ignored.

Decomposition:
- fpu_dp_pkg: fpu_op_e enum (ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11), issue_state_e (IDLE/WAIT/RESP), DP_QNAN constant, DP_W=64.
- No sub-module; a single always_ff FSM plus datapath registers. The integration top instantiates this block beside fpu_dp.

Test Plan:
- Basic add: req a=0x4010CCCCCCCCCCCD (4.2), b=0x400999999999999A (3.2), op=00, tag=3; stub drives fpu_ready=1 with result 0x401D99999999999A two cycles after accept -> rsp_valid with that result, tag=3, flags 0; fpu_a/b held stable through WAIT.
- Stale Ready masking: fpu_ready held at 1 continuously, MIN_WAIT=1 -> capture is not earlier than 2 cycles after accept, and the result is sampled at that cycle.
- Timeout: fpu_ready never asserted -> rsp_valid TIMEOUT cycles after accept with result 0x7FF8000000000000, rsp_to=1, sticky_to=1. Ready and timeout coincident at cnt=TIMEOUT-1 -> real result, rsp_to=0.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 -> rsp fields stable, req_ready=0, busy=1; second request accepted only the cycle after the handshake.
- Sticky: mul returns fpu_overflow=1 -> sticky_ovf=1 after handshake. Pulsing sticky_clr on the same cycle as a div handshake with underflow=1 -> sticky_ovf=0, sticky_unf=1.
- Reset mid-WAIT: drop rst_n asynchronously between edges -> outputs 0 immediately, req_ready=1 after release, no rsp_valid for the dropped request.
